// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two requester ports sharing one single-port synchronous RAM.
// Each transaction walks IDLE -> ACCESS -> RESP, so at most one transaction
// completes every three cycles. The winner's address, write enable and write
// data are captured when it is granted, so the in-flight access is immune to
// later changes on the request inputs.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to break ties in favour of the
// port not granted last. Without it, port 1 has fixed priority.
module mem_port_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    // port 1
    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    output logic          p1_ack_o,
    // port 2
    input  logic          p2_req_i,
    input  logic          p2_we_i,
    input  logic [AW-1:0] p2_addr_i,
    input  logic [DW-1:0] p2_wdata_i,
    output logic          p2_ack_o,
    // read data for the port being acked
    output logic [DW-1:0] rdata_o,
    // RAM side
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          win_q;      // 0: port 1 owns the transaction, 1: port 2
    logic          ram_en_q;
    logic          ram_we_q;
    logic          p1_ack_q;
    logic          p2_ack_q;

    logic          any_req;
    logic          win_d;
    logic          we_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          last_q;     // port granted most recently (1: port 2)
`endif

    // Arbitration: choose the winner and mux its request fields
    always_comb begin
        any_req = p1_req_i | p2_req_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (p1_req_i && p2_req_i) begin
            win_d = ~last_q;
        end else begin
            win_d = p2_req_i;
        end
`else
        win_d = p2_req_i & ~p1_req_i;
`endif
        we_d    = win_d ? p2_we_i    : p1_we_i;
        addr_d  = win_d ? p2_addr_i  : p1_addr_i;
        wdata_d = win_d ? p2_wdata_i : p1_wdata_i;
    end

    // Transaction FSM; RAM strobes and acks are registered so each is
    // exactly one state wide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            win_q    <= 1'b0;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            p1_ack_q <= 1'b0;
            p2_ack_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            p1_ack_q <= 1'b0;
            p2_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q  <= ACCESS;
                        we_q     <= we_d;
                        addr_q   <= addr_d;
                        wdata_q  <= wdata_d;
                        win_q    <= win_d;
                        ram_en_q <= 1'b1;
                        ram_we_q <= we_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_q   <= win_d;
`endif
                    end
                end
                ACCESS: begin
                    state_q  <= RESP;
                    p1_ack_q <= ~win_q;
                    p2_ack_q <= win_q;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM read data lands in RESP; pass it through only for a read
    always_comb begin
        rdata_o = '0;
        if (state_q == RESP && !we_q) begin
            rdata_o = ram_rdata_i;
        end
    end

    assign p1_ack_o    = p1_ack_q;
    assign p2_ack_o    = p2_ack_q;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM environment model, a transaction-level
// reference (grant times, winners, expected memory contents) and a
// per-cycle monitor that compares DUT outputs to the reference expectations.
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int NCYC = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          p1_req, p1_we, p2_req, p2_we;
    logic [AW-1:0] p1_addr, p2_addr;
    logic [DW-1:0] p1_wdata, p2_wdata;
    logic          p1_ack, p2_ack, ram_en, ram_we, busy;
    logic [DW-1:0] rdata, ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [AW-1:0] ram_addr;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_ack_o(p1_ack),
        .p2_req_i(p2_req), .p2_we_i(p2_we), .p2_addr_i(p2_addr), .p2_wdata_i(p2_wdata),
        .p2_ack_o(p2_ack),
        .rdata_o(rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM environment
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Cycle k = the cycle after the k-th rising edge
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Reference expectations per cycle
    bit          e_ack1 [NCYC];
    bit          e_ack2 [NCYC];
    bit          e_en   [NCYC];
    bit          e_we   [NCYC];
    bit          e_busy [NCYC];
    bit [AW-1:0] e_addr [NCYC];
    bit [DW-1:0] e_wdata[NCYC];
    bit [DW-1:0] e_rdata[NCYC];
    bit [DW-1:0] ref_mem [bit [AW-1:0]];
    int          next_arb = 0;   // earliest edge at which a new grant may occur
    bit          last_p2  = 1'b1;

    int passed = 0;
    int total  = 0;
    bit mon_on = 1'b0;

    // Reference: decide the grant (if any) at the upcoming edge
    task automatic model_edge();
        int          e;
        bit          w2, we;
        bit [AW-1:0] a;
        bit [DW-1:0] d;
        e = cyc + 1;
        if (rst && e >= next_arb && (p1_req || p2_req) && e + 1 < NCYC) begin
            if (p1_req && p2_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                w2 = !last_p2;
`else
                w2 = 1'b0;
`endif
            end else begin
                w2 = p2_req;
            end
            last_p2 = w2;
            we = w2 ? p2_we    : p1_we;
            a  = w2 ? p2_addr  : p1_addr;
            d  = w2 ? p2_wdata : p1_wdata;
            e_en[e]     = 1'b1;
            e_we[e]     = we;
            e_addr[e]   = a;
            e_wdata[e]  = d;
            e_busy[e]   = 1'b1;
            e_busy[e+1] = 1'b1;
            if (w2) e_ack2[e+1] = 1'b1;
            else    e_ack1[e+1] = 1'b1;
            if (we) ref_mem[a] = d;
            else    e_rdata[e+1] = ref_mem.exists(a) ? ref_mem[a] : '0;
            next_arb = e + 3;
        end
    endtask

    // Reset drops everything in flight
    task automatic clear_exp(input int from);
        for (int j = from; j < from + 4 && j < NCYC; j++) begin
            e_ack1[j] = 0; e_ack2[j] = 0; e_en[j] = 0; e_we[j] = 0;
            e_busy[j] = 0; e_addr[j] = '0; e_wdata[j] = '0; e_rdata[j] = '0;
        end
        next_arb = 0;
        last_p2  = 1'b1;
    endtask

    task automatic advance();
        model_edge();
        @(negedge clk);
    endtask

    task automatic quiesce();
        p1_req = 0; p2_req = 0;
        repeat (4) advance();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_exp(cyc);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Per-cycle monitor against the reference
    always @(negedge clk) begin
        if (mon_on && cyc < NCYC) begin
            total++;
            if (p1_ack !== e_ack1[cyc]) $display("FAIL p1_ack cyc=%0d got=%b exp=%b", cyc, p1_ack, e_ack1[cyc]);
            else passed++;
            total++;
            if (p2_ack !== e_ack2[cyc]) $display("FAIL p2_ack cyc=%0d got=%b exp=%b", cyc, p2_ack, e_ack2[cyc]);
            else passed++;
            total++;
            if ((p1_ack & p2_ack) !== 1'b0) $display("FAIL both_acks cyc=%0d got=%b exp=0", cyc, p1_ack & p2_ack);
            else passed++;
            total++;
            if (ram_en !== e_en[cyc]) $display("FAIL ram_en cyc=%0d got=%b exp=%b", cyc, ram_en, e_en[cyc]);
            else passed++;
            total++;
            if (ram_we !== (e_en[cyc] & e_we[cyc])) $display("FAIL ram_we cyc=%0d got=%b exp=%b", cyc, ram_we, e_en[cyc] & e_we[cyc]);
            else passed++;
            total++;
            if (busy !== e_busy[cyc]) $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy[cyc]);
            else passed++;
            total++;
            if (rdata !== e_rdata[cyc]) $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, e_rdata[cyc]);
            else passed++;
            if (e_en[cyc]) begin
                total++;
                if (ram_addr !== e_addr[cyc]) $display("FAIL ram_addr cyc=%0d got=%h exp=%h", cyc, ram_addr, e_addr[cyc]);
                else passed++;
                if (e_we[cyc]) begin
                    total++;
                    if (ram_wdata !== e_wdata[cyc]) $display("FAIL ram_wdata cyc=%0d got=%h exp=%h", cyc, ram_wdata, e_wdata[cyc]);
                    else passed++;
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({p1_ack, p2_ack, ram_en, ram_we, busy} !== 5'b0)
            $display("FAIL reset_ctrl got=%b exp=00000", {p1_ack, p2_ack, ram_en, ram_we, busy});
        else passed++;
        total++;
        if (ram_addr !== '0 || ram_wdata !== '0) $display("FAIL reset_ram_bus got=%h/%h exp=0/0", ram_addr, ram_wdata);
        else passed++;
        total++;
        if (rdata !== '0) $display("FAIL reset_rdata got=%h exp=0", rdata);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        mon_on = 1'b1;
    endtask

    task automatic test_write_read();
        int n, ack_at;
        logic [DW-1:0] got;
        quiesce();
        p1_req = 1; p1_we = 1; p1_addr = 16'h0010; p1_wdata = 16'hBEEF;
        n = cyc + 1;
        advance();
        total++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1) $display("FAIL wr_access got=%b%b exp=11", ram_en, ram_we);
        else passed++;
        advance();
        total++;
        if (p1_ack !== 1'b1) $display("FAIL wr_ack got=%b exp=1", p1_ack);
        else passed++;
        p1_req = 0;
        p2_req = 1; p2_we = 0; p2_addr = 16'h0010; p2_wdata = 16'h0;
        ack_at = -1; got = '0;
        for (int i = 0; i < 6; i++) begin
            advance();
            if (p2_ack === 1'b1 && ack_at < 0) begin
                ack_at = cyc; got = rdata; p2_req = 0;
            end
        end
        p2_req = 0;
        // p2 is first arbitrated at edge n+3, so its ack lands in cycle n+4
        total++;
        if (ack_at != n + 4) $display("FAIL rd_ack_time got=%0d exp=%0d", ack_at, n + 4);
        else passed++;
        total++;
        if (got !== 16'hBEEF) $display("FAIL rd_data got=%h exp=beef", got);
        else passed++;
    endtask

    task automatic test_priority();
        int n, a1, a2;
        int order[$];
        int exp_p;
        apply_reset();
        p1_req = 1; p1_we = 0; p1_addr = 16'h0001;
        p2_req = 1; p2_we = 0; p2_addr = 16'h0002;
        n = cyc + 1; a1 = -1; a2 = -1;
        for (int i = 0; i < 8; i++) begin
            advance();
            if (p1_ack === 1'b1) begin if (a1 < 0) a1 = cyc; p1_req = 0; end
            if (p2_ack === 1'b1) begin if (a2 < 0) a2 = cyc; p2_req = 0; end
        end
        total++;
        if (a1 != n + 1) $display("FAIL tie_p1_ack got=%0d exp=%0d", a1, n + 1);
        else passed++;
        total++;
        if (a2 != n + 4) $display("FAIL tie_p2_ack got=%0d exp=%0d", a2, n + 4);
        else passed++;
        // Continuous requests from both ports
        p1_req = 1; p2_req = 1;
        for (int i = 0; i < 12; i++) begin
            advance();
            if (p1_ack === 1'b1) begin order.push_back(1); p1_addr = p1_addr + 1; end
            if (p2_ack === 1'b1) begin order.push_back(2); p2_addr = p2_addr + 1; end
        end
        p1_req = 0; p2_req = 0;
        for (int j = 0; j < 4; j++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_p = (j % 2 == 0) ? 1 : 2;
`else
            exp_p = 1;
`endif
            total++;
            if (j >= order.size() || order[j] != exp_p)
                $display("FAIL grant_order idx=%0d got=%0d exp=%0d", j, (j < order.size()) ? order[j] : 0, exp_p);
            else passed++;
        end
    endtask

    task automatic test_continuous();
        int lows, acks, last_ack;
        quiesce();
        p2_req = 1; p2_we = 0; p2_addr = 16'($urandom_range(0, 15));
        lows = 0; acks = 0; last_ack = -1;
        for (int i = 0; i < 15; i++) begin
            advance();
            if (busy === 1'b0) lows++;
            if (p2_ack === 1'b1) begin
                acks++;
                if (last_ack >= 0) begin
                    total++;
                    if (cyc - last_ack != 3) $display("FAIL p2_ack_gap got=%0d exp=3", cyc - last_ack);
                    else passed++;
                end
                last_ack = cyc;
                p2_addr = 16'($urandom_range(0, 15));
            end
        end
        p2_req = 0;
        total++;
        if (lows != 5) $display("FAIL busy_low_count got=%0d exp=5", lows);
        else passed++;
        total++;
        if (acks != 5) $display("FAIL p2_ack_count got=%0d exp=5", acks);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int r;
        quiesce();
        p1_req = 1; p1_we = 0; p1_addr = 16'h0004;
        model_edge();
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_exp(cyc);
        #1;
        total++;
        if ({ram_en, busy, p1_ack} !== 3'b000) $display("FAIL abort_outputs got=%b exp=000", {ram_en, busy, p1_ack});
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        r = cyc + 1;
        advance();
        total++;
        if (ram_en !== 1'b1 || ram_addr !== 16'h0004) $display("FAIL post_reset_access got=%b/%h exp=1/0004", ram_en, ram_addr);
        else passed++;
        advance();
        total++;
        if (p1_ack !== 1'b1 || cyc != r + 1) $display("FAIL post_reset_ack got=%b@%0d exp=1@%0d", p1_ack, cyc, r + 1);
        else passed++;
        p1_req = 0;
    endtask

    task automatic test_addr_change();
        quiesce();
        p1_req = 1; p1_we = 1; p1_addr = 16'h0020; p1_wdata = 16'hA5A5;
        repeat (3) advance();
        p1_addr = 16'h0030; p1_wdata = 16'h5A5A;
        repeat (3) advance();
        p1_we = 0; p1_addr = 16'h0020;
        advance();
        p1_addr = 16'h0030;
        total++;
        if (ram_addr !== 16'h0020) $display("FAIL addr_hold_access got=%h exp=0020", ram_addr);
        else passed++;
        advance();
        total++;
        if (p1_ack !== 1'b1 || rdata !== 16'hA5A5) $display("FAIL addr_hold_resp got=%b/%h exp=1/a5a5", p1_ack, rdata);
        else passed++;
        p1_req = 0;
        advance();
    endtask

    task automatic test_random();
        quiesce();
        for (int i = 0; i < 1500; i++) begin
            if (!p1_req || e_ack1[cyc]) begin
                p1_req   = ($urandom_range(0, 99) < 45);
                p1_we    = 1'($urandom_range(0, 1));
                p1_addr  = 16'($urandom_range(0, 15));
                p1_wdata = 16'($urandom);
            end
            if (!p2_req || e_ack2[cyc]) begin
                p2_req   = ($urandom_range(0, 99) < 45);
                p2_we    = 1'($urandom_range(0, 1));
                p2_addr  = 16'($urandom_range(0, 15));
                p2_wdata = 16'($urandom);
            end
            advance();
        end
        quiesce();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        p2_req = 0; p2_we = 0; p2_addr = '0; p2_wdata = '0;
        test_reset();
        test_write_read();
        test_priority();
        test_continuous();
        test_reset_abort();
        test_addr_change();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
